// File: rtl/rom_arb_pkg.sv
// Shared constants and helpers for the ROM read-port arbiter.
package rom_arb_pkg;

  localparam int ROM_LAT      = 1;
  localparam int DEF_DW       = 8;
  localparam int DEF_AW       = 14;
  localparam int DEF_NREQ     = 2;

  // Width of a port index, never narrower than one bit.
  function automatic int tag_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/rom_arb_pick.sv
// Combinational rotate-mask priority picker: lowest requester at or above
// start wins, falling back to the lowest requester overall.
module rom_arb_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx
);

  logic [N-1:0] mask;
  logic [N-1:0] masked;
  logic [N-1:0] pick_src;

  assign mask     = ~((N'(1) << start) - N'(1));
  assign masked   = req & mask;
  assign pick_src = (masked != '0) ? masked : req;
  // Isolate the lowest set bit.
  assign win      = pick_src & (~pick_src + N'(1));

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (win[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Arbitrates NREQ read requesters onto one 1-cycle-latency synchronous ROM.
// Define ROM_ARB_RR_EN for round-robin arbitration; fixed priority otherwise.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int AW   = DEF_AW,
  parameter int NREQ = DEF_NREQ
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [NREQ*DW-1:0] rdata,
  output logic             rom_ce,
  output logic [AW-1:0]    rom_a,
  input  logic [DW-1:0]    rom_d
);

  localparam int TW = tag_width(NREQ);

  logic [TW-1:0]      start;
  logic [TW-1:0]      win_idx;
  logic [NREQ-1:0]    win_oh;
  logic [TW-1:0]      tag_q;
  logic               pend_q;
  logic [NREQ*DW-1:0] rdata_q;

  rom_arb_pick #(
    .N  (NREQ),
    .IW (TW)
  ) u_pick (
    .req   (req),
    .start (start),
    .win   (win_oh),
    .idx   (win_idx)
  );

`ifdef ROM_ARB_RR_EN
  logic [TW-1:0] last_q;

  assign start = (last_q == TW'(NREQ - 1)) ? '0 : last_q + TW'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= TW'(NREQ - 1);
    end else if (rom_ce) begin
      last_q <= win_idx;
    end
  end
`else
  assign start = '0;
`endif

  // Request-side outputs are held at zero while reset is asserted.
  assign rom_ce = reset_n & (|req);
  assign gnt    = reset_n ? win_oh : '0;

  always_comb begin
    rom_a = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) rom_a = addr[i*AW +: AW];
    end
  end

  always_comb begin
    rvalid = '0;
    for (int i = 0; i < NREQ; i++) begin
      rvalid[i] = pend_q && (tag_q == TW'(i));
    end
  end

  // The returning port sees rom_d directly so data and rvalid coincide.
  always_comb begin
    rdata = rdata_q;
    for (int i = 0; i < NREQ; i++) begin
      if (rvalid[i]) rdata[i*DW +: DW] = rom_d;
    end
  end

  // NOTE: the rdata holding registers are reset too, so every port reads 0 until its first return.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_q  <= 1'b0;
      tag_q   <= '0;
      rdata_q <= '0;
    end else begin
      pend_q <= rom_ce;
      tag_q  <= win_idx;
      for (int i = 0; i < NREQ; i++) begin
        if (rvalid[i]) rdata_q[i*DW +: DW] <= rom_d;
      end
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed and randomized bench for rom_arbiter against a cycle-level model
// of its arbitration rules and a synchronous ROM.
module tb_rom_arbiter;

  localparam int DW = 8;
  localparam int AW = 14;
  localparam int N  = 2;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [N*AW-1:0] addr;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rvalid;
  logic [N*DW-1:0] rdata;
  logic           rom_ce;
  logic [AW-1:0]  rom_a;
  logic [DW-1:0]  rom_d;

  logic [DW-1:0]  mem [2**AW];

  int tests = 0;
  int fails = 0;
  int last_m;
  int last_w;
  logic [DW-1:0] exp_rd [N];

  rom_arbiter #(
    .DW   (DW),
    .AW   (AW),
    .NREQ (N)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .addr    (addr),
    .gnt     (gnt),
    .rvalid  (rvalid),
    .rdata   (rdata),
    .rom_ce  (rom_ce),
    .rom_a   (rom_a),
    .rom_d   (rom_d)
  );

  always #5 clock = ~clock;

  // Synchronous ROM with clock enable, one cycle of read latency.
  always @(posedge clock) begin
    if (rom_ce) rom_d <= mem[rom_a];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Winner index from the request vector, or -1 when nobody asks.
  function automatic int model_pick(input logic [N-1:0] r);
    if (r == '0) return -1;
`ifdef ROM_ARB_RR_EN
    for (int k = 1; k <= N; k++) begin
      if (r[(last_m + k) % N]) return (last_m + k) % N;
    end
`else
    for (int i = 0; i < N; i++) begin
      if (r[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic cycle(input logic [N-1:0] r, input logic [AW-1:0] a0,
                       input logic [AW-1:0] a1, input string tag);
    logic [AW-1:0] av [N];
    logic [N-1:0]  eg;
    logic [AW-1:0] ea;
    int w;
    av[0] = a0;
    av[1] = a1;
    @(negedge clock);
    req  = r;
    addr = {a1, a0};
    #1;
    w  = model_pick(r);
    eg = '0;
    ea = '0;
    if (w >= 0) begin
      eg = N'(1) << w;
      ea = av[w];
    end
    check({tag, "_gnt"},    64'(gnt),    64'(eg));
    check({tag, "_rom_ce"}, 64'(rom_ce), 64'(w >= 0));
    check({tag, "_rom_a"},  64'(rom_a),  64'(ea));
    @(posedge clock);
    #1;
    if (w >= 0) begin
      exp_rd[w] = mem[ea];
      last_m    = w;
    end
    check({tag, "_rvalid"}, 64'(rvalid), 64'(eg));
    check({tag, "_rdata"},  64'(rdata),  64'({exp_rd[1], exp_rd[0]}));
    last_w = w;
  endtask

  initial begin
    logic [N-1:0]  rq;
    logic [AW-1:0] ra [N];

    for (int i = 0; i < 2**AW; i++) mem[i] = DW'($urandom);
    mem[14'h0100] = 8'hA5;
    mem[14'h0200] = 8'h3C;
    rom_d   = '0;
    reset_n = 1'b0;
    req     = 2'b11;
    addr    = {14'h0123, 14'h0045};
    last_m  = N - 1;
    last_w  = -1;
    for (int i = 0; i < N; i++) exp_rd[i] = '0;

    // Reset held with both ports requesting.
    repeat (2) @(posedge clock);
    #1;
    check("rst_gnt",    64'(gnt),    64'(0));
    check("rst_rom_ce", 64'(rom_ce), 64'(0));
    check("rst_rom_a",  64'(rom_a),  64'(0));
    check("rst_rvalid", 64'(rvalid), 64'(0));
    check("rst_rdata",  64'(rdata),  64'(0));
    @(negedge clock);
    req     = '0;
    reset_n = 1'b1;

    cycle(2'b11, 14'h0005, 14'h0006, "first");
    check("first_port0", 64'(rvalid), 64'(2'b01));

    // Single request on port 1.
    cycle(2'b10, 14'h0000, 14'h0100, "single");
    check("single_rdata1", 64'(rdata[15:8]), 64'(8'hA5));
    cycle(2'b00, 14'h0000, 14'h0000, "idle");

    // Contention; the next step sees port 1 alone.
    repeat (4) cycle(2'b11, 14'h0010, 14'h0020, "cont");
    cycle(2'b10, 14'h0010, 14'h0020, "cont_p1");

    // Back-to-back streaming on port 0.
    for (int i = 0; i < 16; i++) cycle(2'b01, AW'(i), 14'h0000, "stream");
    cycle(2'b00, 14'h0000, 14'h0000, "stream_end");

    // Randomized traffic obeying the hold-until-granted rule.
    rq = N'($urandom);
    for (int p = 0; p < N; p++) ra[p] = AW'($urandom);
    repeat (60) begin
      cycle(rq, ra[0], ra[1], "rand");
      for (int p = 0; p < N; p++) begin
        if (last_w == p || !rq[p]) begin
          rq[p] = 1'($urandom_range(0, 1));
          ra[p] = AW'($urandom);
        end
      end
    end
    cycle(2'b00, 14'h0000, 14'h0000, "rand_end");

    // Reset in the cycle after a grant to port 1.
    @(negedge clock);
    req  = 2'b10;
    addr = {14'h0200, 14'h0000};
    #1;
    check("mid_gnt", 64'(gnt), 64'(2'b10));
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    req     = 2'b11;
    #1;
    check("mid_rst_rvalid", 64'(rvalid), 64'(0));
    check("mid_rst_gnt",    64'(gnt),    64'(0));
    check("mid_rst_rom_ce", 64'(rom_ce), 64'(0));
    check("mid_rst_rdata",  64'(rdata),  64'(0));
    repeat (2) @(posedge clock);
    @(negedge clock);
    req     = '0;
    reset_n = 1'b1;
    last_m  = N - 1;
    for (int i = 0; i < N; i++) exp_rd[i] = '0;
    @(posedge clock);
    #1;
    check("mid_rel_rvalid", 64'(rvalid),      64'(0));
    check("mid_rel_rdata1", 64'(rdata[15:8]), 64'(0));
    cycle(2'b11, 14'h0300, 14'h0301, "mid_first");
    check("mid_first_port0", 64'(rvalid), 64'(2'b01));
    cycle(2'b00, 14'h0000, 14'h0000, "final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
